// File: rtl/etch_a_sketch_main.sv
// etch_a_sketch_main: ILI9341 bring-up over 4-wire 8-bit SPI, then endless 240x320 RGB565 frames.
// Optional build macro TOUCH_IRQ_EN: palette steps on touch_irq falling edges instead of every frame.
module etch_a_sketch_main #(
  parameter int CLK_HZ      = 12_000_000,
  parameter int RST_CYCLES  = 1_200,
  parameter int WAKE_CYCLES = 1_440_000,
  parameter int H_PIXELS    = 240,
  parameter int V_PIXELS    = 320
) (
  input  logic       clk,
  input  logic [1:0] buttons,
  output logic [1:0] leds,
  output logic [2:0] rgb,
  output logic [7:0] pmod,
  output logic [3:0] interface_mode,
  inout  wire        touch_i2c_scl,
  inout  wire        touch_i2c_sda,
  input  logic       touch_irq,
  output logic       backlight,
  output logic       display_rstb,
  output logic       data_commandb,
  output logic       display_csb,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_clk
);

  // state    | meaning
  // S_RST    | display_rstb low for RST_CYCLES
  // S_WAKE1  | rstb released, wait WAKE_CYCLES
  // S_CSB    | chip select asserted one clk ahead of the first bit
  // S_SLPOUT | send sleep-out command 0x11
  // S_WAKE2  | wait WAKE_CYCLES after sleep-out
  // S_INIT   | send pixel format / orientation / display-on bytes
  // S_HDR    | send column/row window and memory-write command
  // S_PIX    | stream one frame of pixels, two bytes each
  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_WAKE1  = 4'd1,
    S_CSB    = 4'd2,
    S_SLPOUT = 4'd3,
    S_WAKE2  = 4'd4,
    S_INIT   = 4'd5,
    S_HDR    = 4'd6,
    S_PIX    = 4'd7
  } state_t;

  localparam int TMAX = (WAKE_CYCLES > RST_CYCLES) ? WAKE_CYCLES : RST_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] RST_LOAD  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] WAKE_LOAD = TW'(WAKE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [16:0]   PIX_LAST  = 17'(H_PIXELS * V_PIXELS - 1);

  state_t        state, state_nxt;
  logic          rst;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cyc;
  logic [3:0]    byte_idx;
  logic [16:0]   pix_cnt;
  logic [2:0]    idx;
  logic          frame_par;
  logic          backlight_q;
  logic          hold_meta, hold_sync;
  logic          sending, byte_done, frame_end, step_ok;
  logic [8:0]    cur_word;
  logic [2:0]    bit_sel;
  logic [15:0]   colour;
  logic          unused_ok;

  assign rst = buttons[0];

  function automatic logic [8:0] init_word(input logic [3:0] i);
    case (i)
      4'd0:    init_word = {1'b0, 8'h3A};
      4'd1:    init_word = {1'b1, 8'h55};
      4'd2:    init_word = {1'b0, 8'h36};
      4'd3:    init_word = {1'b1, 8'h48};
      default: init_word = {1'b0, 8'h29};
    endcase
  endfunction

  function automatic logic [8:0] hdr_word(input logic [3:0] i);
    case (i)
      4'd0:    hdr_word = {1'b0, 8'h2A};
      4'd4:    hdr_word = {1'b1, 8'hEF};
      4'd5:    hdr_word = {1'b0, 8'h2B};
      4'd8:    hdr_word = {1'b1, 8'h01};
      4'd9:    hdr_word = {1'b1, 8'h3F};
      4'd10:   hdr_word = {1'b0, 8'h2C};
      default: hdr_word = {1'b1, 8'h00};
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    sending   = 1'b0;
    case (state)
      S_RST:    if (timer == '0) state_nxt = S_WAKE1;
      S_WAKE1:  if (timer == '0) state_nxt = S_CSB;
      S_CSB:    state_nxt = S_SLPOUT;
      S_SLPOUT: begin
        sending = 1'b1;
        if (bit_cyc == 4'd15) state_nxt = S_WAKE2;
      end
      S_WAKE2:  if (timer == '0) state_nxt = S_INIT;
      S_INIT: begin
        sending = 1'b1;
        if (bit_cyc == 4'd15 && byte_idx == 4'd4) state_nxt = S_HDR;
      end
      S_HDR: begin
        sending = 1'b1;
        if (bit_cyc == 4'd15 && byte_idx == 4'd10) state_nxt = S_PIX;
      end
      S_PIX: begin
        sending = 1'b1;
        if (bit_cyc == 4'd15 && byte_idx[0] && pix_cnt == PIX_LAST) state_nxt = S_HDR;
      end
      default:  state_nxt = S_RST;
    endcase
  end

  assign byte_done = sending && (bit_cyc == 4'd15);
  assign frame_end = (state == S_PIX) && (state_nxt == S_HDR);
  assign colour    = {{5{idx[2]}}, {6{idx[1]}}, {5{idx[0]}}};

  always_comb begin
    cur_word = 9'h000;
    case (state)
      S_SLPOUT: cur_word = {1'b0, 8'h11};
      S_INIT:   cur_word = init_word(byte_idx);
      S_HDR:    cur_word = hdr_word(byte_idx);
      S_PIX:    cur_word = {1'b1, byte_idx[0] ? colour[7:0] : colour[15:8]};
      default:  cur_word = 9'h000;
    endcase
  end

`ifdef TOUCH_IRQ_EN
  logic irq_meta, irq_sync, irq_prev, touch_pending;

  // One pending step per frame; an edge landing on frame_end carries into the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_meta      <= 1'b1;
      irq_sync      <= 1'b1;
      irq_prev      <= 1'b1;
      touch_pending <= 1'b0;
    end else begin
      irq_meta      <= touch_irq;
      irq_sync      <= irq_meta;
      irq_prev      <= irq_sync;
      touch_pending <= (irq_prev & ~irq_sync) | (touch_pending & ~frame_end);
    end
  end

  assign step_ok = touch_pending;
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RST;
      timer       <= RST_LOAD;
      bit_cyc     <= 4'd0;
      byte_idx    <= 4'd0;
      pix_cnt     <= '0;
      idx         <= 3'd0;
      frame_par   <= 1'b0;
      backlight_q <= 1'b0;
      hold_meta   <= 1'b0;
      hold_sync   <= 1'b0;
    end else begin
      state       <= state_nxt;
      backlight_q <= 1'b1;
      hold_meta   <= buttons[1];
      hold_sync   <= hold_meta;

      if (state_nxt != state && (state_nxt == S_WAKE1 || state_nxt == S_WAKE2))
        timer <= WAKE_LOAD;
      else if (timer != '0)
        timer <= timer - TIMER_ONE;

      bit_cyc <= sending ? bit_cyc + 4'd1 : 4'd0;

      // In S_PIX byte_idx only flips between high and low byte of a pixel.
      if (state_nxt != state)
        byte_idx <= 4'd0;
      else if (byte_done)
        byte_idx <= (state == S_PIX) ? {3'b000, ~byte_idx[0]} : byte_idx + 4'd1;

      if (state != S_PIX)
        pix_cnt <= '0;
      else if (byte_done && byte_idx[0])
        pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 17'd1;

      if (frame_end) begin
        frame_par <= ~frame_par;
        if (step_ok && !hold_sync) idx <= idx + 3'd1;
      end
    end
  end

  assign bit_sel        = ~bit_cyc[3:1];
  assign spi_clk        = sending & bit_cyc[0];
  assign spi_mosi       = sending & cur_word[bit_sel];
  assign data_commandb  = sending & cur_word[8];
  assign display_csb    = (state == S_RST) || (state == S_WAKE1);
  assign display_rstb   = (state != S_RST);
  assign backlight      = backlight_q;
  assign leds           = {frame_par, (state == S_HDR) || (state == S_PIX)};
  assign rgb            = ~idx;
  assign pmod           = {spi_clk, spi_mosi, display_csb, data_commandb, state};
  assign interface_mode = 4'b1110;
  assign touch_i2c_scl  = 1'bz;
  assign touch_i2c_sda  = 1'bz;
  assign unused_ok      = ^{spi_miso, touch_irq, CLK_HZ[0]};

endmodule

// File: tb/tb_etch_a_sketch_main.sv
// Bench for etch_a_sketch_main: captures the SPI byte stream and compares it with a frame-level model.
`timescale 1ns/1ps
module tb_etch_a_sketch_main;
  localparam int RST_C  = 24;
  localparam int WAKE_C = 60;
  localparam int H      = 4;
  localparam int V      = 2;
  localparam int NPIX   = H * V;

  logic       clk = 1'b0;
  logic [1:0] buttons;
  logic [1:0] leds;
  logic [2:0] rgb;
  logic [7:0] pmod;
  logic [3:0] interface_mode;
  wire        touch_scl, touch_sda;
  logic       touch_irq;
  logic       backlight, display_rstb, data_commandb, display_csb, spi_mosi, spi_miso, spi_clk;

  always #5 clk = ~clk;

  etch_a_sketch_main #(
    .CLK_HZ(12_000_000), .RST_CYCLES(RST_C), .WAKE_CYCLES(WAKE_C),
    .H_PIXELS(H), .V_PIXELS(V)
  ) dut (
    .clk(clk), .buttons(buttons), .leds(leds), .rgb(rgb), .pmod(pmod),
    .interface_mode(interface_mode), .touch_i2c_scl(touch_scl), .touch_i2c_sda(touch_sda),
    .touch_irq(touch_irq), .backlight(backlight), .display_rstb(display_rstb),
    .data_commandb(data_commandb), .display_csb(display_csb), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_clk(spi_clk)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // SPI capture: one entry per completed byte, {dc, data}, plus the clk count at its last bit.
  logic [8:0] cap_q[$];
  int         ts_q[$];
  int         cyc_cnt = 0;
  int         bitcnt = 0;
  logic [7:0] shreg = 8'h00;
  logic       cur_dc = 1'b0;
  int         dc_glitch = 0;

  always @(negedge clk) begin
    cyc_cnt++;
    if (display_csb !== 1'b0) begin
      bitcnt = 0;
    end else if (spi_clk === 1'b1) begin
      if (bitcnt == 0) cur_dc = data_commandb;
      else if (data_commandb !== cur_dc) dc_glitch++;
      shreg = {shreg[6:0], spi_mosi};
      bitcnt++;
      if (bitcnt == 8) begin
        cap_q.push_back({cur_dc, shreg});
        ts_q.push_back(cyc_cnt);
        bitcnt = 0;
      end
    end
  end

  int idx_m, par_m, prev_ts;

  task automatic get_byte(output logic [8:0] w, output int ts, output bit ok);
    int waited = 0;
    w = '0; ts = 0; ok = 1'b0;
    while (cap_q.size() == 0 && waited < 1000) begin
      @(negedge clk); #1;
      waited++;
    end
    if (cap_q.size() != 0) begin
      w  = cap_q.pop_front();
      ts = ts_q.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    buttons = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    n_assert++; if (display_rstb !== 1'b0) begin n_fail++; $display("FAIL rst_rstb: got %b want 0", display_rstb); end
    n_assert++; if (display_csb !== 1'b1) begin n_fail++; $display("FAIL rst_csb: got %b want 1", display_csb); end
    n_assert++; if (backlight !== 1'b0) begin n_fail++; $display("FAIL rst_backlight: got %b want 0", backlight); end
    n_assert++; if (leds !== 2'b00) begin n_fail++; $display("FAIL rst_leds: got %b want 00", leds); end
    n_assert++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL rst_rgb: got %b want 111", rgb); end
    n_assert++; if (pmod !== 8'h20) begin n_fail++; $display("FAIL rst_pmod: got %h want 20", pmod); end
    n_assert++; if (interface_mode !== 4'b1110) begin n_fail++; $display("FAIL if_mode: got %b want 1110", interface_mode); end
    @(negedge clk);
    buttons = 2'b00;
  endtask

  task automatic test_bringup();
    int cnt;
    int ts, ts0;
    bit ok;
    logic [8:0] w;
    logic [8:0] exp_init [6];
    exp_init = '{9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
    cap_q.delete();
    ts_q.delete();
    ts0 = 0;

    cnt = 0;
    while (display_rstb !== 1'b1 && cnt < RST_C + 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_assert++; if (cnt !== RST_C) begin n_fail++; $display("FAIL rstb_low_cycles: got %0d want %0d", cnt, RST_C); end
    n_assert++; if (backlight !== 1'b1) begin n_fail++; $display("FAIL backlight_on: got %b want 1", backlight); end
    n_assert++; if (display_csb !== 1'b1) begin n_fail++; $display("FAIL csb_wake1: got %b want 1", display_csb); end

    cnt = 0;
    while (display_csb !== 1'b0 && cnt < WAKE_C + 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_assert++; if (cnt !== WAKE_C) begin n_fail++; $display("FAIL wake1_cycles: got %0d want %0d", cnt, WAKE_C); end

    for (int i = 0; i < 6; i++) begin
      get_byte(w, ts, ok);
      n_assert++;
      if (!ok || w !== exp_init[i]) begin
        n_fail++;
        $display("FAIL init_byte%0d: got %h (captured=%0d) want %h", i, w, ok, exp_init[i]);
      end
      if (i == 0) ts0 = ts;
      if (i == 1) begin
        n_assert++;
        if (ts - ts0 !== WAKE_C + 16) begin
          n_fail++;
          $display("FAIL wake2_gap: got %0d want %0d", ts - ts0, WAKE_C + 16);
        end
      end
    end
    prev_ts = ts;
    idx_m   = 0;
    par_m   = 0;
  endtask

  task automatic test_frames(input int nf);
    logic [8:0]  hdr [11];
    logic [8:0]  w, e;
    logic [15:0] colour;
    logic [2:0]  im;
    int          ts;
    bit          ok, hold;
    hdr = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};
    for (int f = 0; f < nf; f++) begin
      hold   = (f == 2) ? 1'b1 : ((f >= 10) ? 1'($urandom_range(0, 1)) : 1'b0);
      colour = ((idx_m & 4) != 0 ? 16'hF800 : 16'h0000) |
               ((idx_m & 2) != 0 ? 16'h07E0 : 16'h0000) |
               ((idx_m & 1) != 0 ? 16'h001F : 16'h0000);
      im = 3'(idx_m);
      for (int b = 0; b < 11 + 2 * NPIX; b++) begin
        if (b < 11) e = hdr[b];
        else if (((b - 11) % 2) == 0) e = {1'b1, colour[15:8]};
        else e = {1'b1, colour[7:0]};
        get_byte(w, ts, ok);
        n_assert++;
        if (!ok || w !== e) begin
          n_fail++;
          $display("FAIL frame%0d_byte%0d: got %h (captured=%0d) want %h", f, b, w, ok, e);
        end
        n_assert++;
        if (ts - prev_ts !== 16) begin
          n_fail++;
          $display("FAIL byte_spacing f%0d b%0d: got %0d want 16", f, b, ts - prev_ts);
        end
        prev_ts = ts;
        if (b == 0) begin
          n_assert++;
          if (rgb !== ~im) begin n_fail++; $display("FAIL frame%0d_rgb: got %b want %b", f, rgb, ~im); end
          n_assert++;
          if (leds !== {par_m[0], 1'b1}) begin
            n_fail++;
            $display("FAIL frame%0d_leds: got %b want %b", f, leds, {par_m[0], 1'b1});
          end
        end
        if (b == 10) buttons[1] = hold;
      end
      par_m ^= 1;
      if (!hold) idx_m = (idx_m + 1) % 8;
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] w;
    int ts;
    bit ok;
    for (int i = 0; i < 12; i++) get_byte(w, ts, ok);
    repeat (5) @(negedge clk);
    #1;
    buttons = 2'b01;
    @(posedge clk); #1;
    n_assert++; if (display_csb !== 1'b1) begin n_fail++; $display("FAIL mid_csb: got %b want 1", display_csb); end
    n_assert++; if (display_rstb !== 1'b0) begin n_fail++; $display("FAIL mid_rstb: got %b want 0", display_rstb); end
    n_assert++; if (spi_clk !== 1'b0) begin n_fail++; $display("FAIL mid_spi_clk: got %b want 0", spi_clk); end
    n_assert++; if ({spi_mosi, data_commandb} !== 2'b00) begin n_fail++; $display("FAIL mid_mosi_dc: got %b want 00", {spi_mosi, data_commandb}); end
    n_assert++; if (leds !== 2'b00) begin n_fail++; $display("FAIL mid_leds: got %b want 00", leds); end
    n_assert++; if (rgb !== 3'b111) begin n_fail++; $display("FAIL mid_rgb: got %b want 111", rgb); end
    n_assert++; if (pmod[3:0] !== 4'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", pmod[3:0]); end
    @(negedge clk);
    buttons = 2'b00;
  endtask

  initial begin
    buttons   = 2'b11;
    touch_irq = 1'b1;
    spi_miso  = 1'b0;
    test_reset();
    test_bringup();
    test_frames(13);
    test_reset_mid();
    test_bringup();
    test_frames(3);
    n_assert++;
    if (dc_glitch !== 0) begin n_fail++; $display("FAIL dc_stable: got %0d changes want 0", dc_glitch); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
